// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: platformer game-flow controller.
// Generates the game tick, runs the level/lives state machine, keeps a
// saturating score and animates an oscillating lava level whose speed grows
// with each jump landing. Drives freeze, spawn and level selection.
module game_flow_ctrl #(
  parameter int TICK_DIV    = 833333,
  parameter int NUM_LEVELS  = 4,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 16,
  parameter int LEVEL_BONUS = 10,
  parameter int LAVA_W      = 10,
  parameter int LAVA_TOP    = 380,
  parameter int LAVA_SPEED  = 3,
  parameter int BOOST_STEP  = 1,
  parameter int MAX_SPEED   = 8,
  parameter int DEATH_TICKS = 60,
  parameter int CLEAR_TICKS = 30,
  parameter int SPAWN_X     = 20,
  parameter int SPAWN_Y     = 344,
  localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int LIFE_W     = (LIVES > 0) ? $clog2(LIVES + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause_btn,
  input  logic               in_lava,
  input  logic               at_goal,
  input  logic               jump_landed,
  output logic               game_tick,
  output logic [2:0]         state,
  output logic               freeze,
  output logic [LVL_W-1:0]   level,
  output logic [LIFE_W-1:0]  lives,
  output logic [SCORE_W-1:0] score,
  output logic [LAVA_W-1:0]  lava_height,
  output logic               lava_rising,
  output logic               spawn_pulse,
  output logic [9:0]         spawn_x,
  output logic [9:0]         spawn_y
);

  localparam int TCK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SPD_W   = (MAX_SPEED > 1) ? $clog2(MAX_SPEED + 1) : 1;
  localparam int TMR_MAX = (DEATH_TICKS > CLEAR_TICKS) ? DEATH_TICKS : CLEAR_TICKS;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUNNING = 3'd1,
    S_PAUSED  = 3'd2,
    S_DYING   = 3'd3,
    S_CLEAR   = 3'd4,
    S_OVER    = 3'd5,
    S_WIN     = 3'd6
  } state_t;

  state_t             state_q;
  logic [TCK_W-1:0]   tick_cnt;
  logic               pause_prev;
  logic               pause_req;
  logic               land_req;
  logic [SPD_W-1:0]   speed;
  logic [TMR_W-1:0]   timer;

  logic [LAVA_W:0]    lava_sum;
  logic [LAVA_W:0]    speed_ext;
  logic [LAVA_W-1:0]  lava_next;
  logic               rising_next;
  logic [SPD_W:0]     spd_sum;
  logic [SPD_W-1:0]   speed_next;
  logic [SCORE_W:0]   sc_inc;
  logic [SCORE_W:0]   sc_bonus;
  logic [SCORE_W-1:0] score_inc;
  logic [SCORE_W-1:0] score_bonus;

  assign state   = state_q;
  assign freeze  = (state_q != S_RUNNING);
  assign spawn_x = 10'(SPAWN_X);
  assign spawn_y = 10'(SPAWN_Y);

  // Tick divider plus latched pause-edge and landing requests.
  // Requests are dropped on every tick edge (used or not) so a stale press
  // never leaks into a later state; a new event on that same edge survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt   <= '0;
      game_tick  <= 1'b0;
      pause_prev <= 1'b0;
      pause_req  <= 1'b0;
      land_req   <= 1'b0;
    end else begin
      if (tick_cnt == TCK_W'(TICK_DIV - 1)) begin
        tick_cnt  <= '0;
        game_tick <= 1'b1;
      end else begin
        tick_cnt  <= tick_cnt + 1'b1;
        game_tick <= 1'b0;
      end
      pause_prev <= pause_btn;
      pause_req  <= (pause_btn & ~pause_prev) | (pause_req & ~game_tick);
      land_req   <= jump_landed | (land_req & ~game_tick);
    end
  end

  // Next lava position, boosted speed and saturated score candidates.
  always_comb begin
    speed_ext   = (LAVA_W + 1)'(speed);
    lava_sum    = {1'b0, lava_height} + speed_ext;
    lava_next   = lava_height;
    rising_next = lava_rising;
    if (lava_rising) begin
      if (lava_sum >= (LAVA_W + 1)'(LAVA_TOP)) begin
        lava_next   = LAVA_W'(LAVA_TOP);
        rising_next = 1'b0;
      end else begin
        lava_next   = lava_sum[LAVA_W-1:0];
      end
    end else begin
      if ({1'b0, lava_height} <= speed_ext) begin
        lava_next   = '0;
        rising_next = 1'b1;
      end else begin
        lava_next   = lava_height - speed_ext[LAVA_W-1:0];
      end
    end

    spd_sum    = {1'b0, speed} + (SPD_W + 1)'(BOOST_STEP);
    speed_next = (spd_sum >= (SPD_W + 1)'(MAX_SPEED)) ? SPD_W'(MAX_SPEED) : spd_sum[SPD_W-1:0];

    sc_inc      = {1'b0, score} + 1'b1;
    sc_bonus    = {1'b0, score} + (SCORE_W + 1)'(LEVEL_BONUS);
    score_inc   = sc_inc[SCORE_W]   ? '1 : sc_inc[SCORE_W-1:0];
    score_bonus = sc_bonus[SCORE_W] ? '1 : sc_bonus[SCORE_W-1:0];
  end

  // Game state machine; all game state advances only on tick edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      level       <= '0;
      lives       <= LIFE_W'(LIVES);
      score       <= '0;
      lava_height <= '0;
      lava_rising <= 1'b1;
      speed       <= SPD_W'(LAVA_SPEED);
      timer       <= '0;
      spawn_pulse <= 1'b0;
    end else begin
      spawn_pulse <= 1'b0;
      if (game_tick) begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q     <= S_RUNNING;
              level       <= '0;
              lives       <= LIFE_W'(LIVES);
              score       <= '0;
              lava_height <= '0;
              lava_rising <= 1'b1;
              speed       <= SPD_W'(LAVA_SPEED);
              spawn_pulse <= 1'b1;
            end
          end
          S_RUNNING: begin
            if (in_lava) begin
              state_q <= S_DYING;
              timer   <= TMR_W'(DEATH_TICKS - 1);
              if (lives != '0) lives <= lives - 1'b1;
            end else if (at_goal) begin
              score <= score_bonus;
              if (level == LVL_W'(NUM_LEVELS - 1)) begin
                state_q <= S_WIN;
              end else begin
                state_q <= S_CLEAR;
                timer   <= TMR_W'(CLEAR_TICKS - 1);
              end
            end else if (pause_req) begin
              state_q <= S_PAUSED;
            end else begin
              lava_height <= lava_next;
              lava_rising <= rising_next;
              if (land_req) begin
                score <= score_inc;
                speed <= speed_next;
              end
            end
          end
          S_PAUSED: begin
            if (pause_req) state_q <= S_RUNNING;
          end
          S_DYING: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else if (lives == '0) begin
              state_q <= S_OVER;
            end else begin
              state_q     <= S_RUNNING;
              lava_height <= '0;
              lava_rising <= 1'b1;
              speed       <= SPD_W'(LAVA_SPEED);
              spawn_pulse <= 1'b1;
            end
          end
          S_CLEAR: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              state_q     <= S_RUNNING;
              level       <= level + 1'b1;
              lava_height <= '0;
              lava_rising <= 1'b1;
              speed       <= SPD_W'(LAVA_SPEED);
              spawn_pulse <= 1'b1;
            end
          end
          S_OVER, S_WIN: begin
            if (start) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a fast tick, short timers, a low
// lava ceiling and a 4-bit score so saturation is reachable.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, pause_btn, in_lava, at_goal, jump_landed;
  logic       game_tick, freeze, lava_rising, spawn_pulse;
  logic [2:0] state;
  logic [1:0] level;
  logic [1:0] lives;
  logic [3:0] score;
  logic [9:0] lava_height, spawn_x, spawn_y;

  int total = 0;
  int bad   = 0;
  int last_n;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .TICK_DIV(4), .NUM_LEVELS(4), .LIVES(3), .SCORE_W(4), .LEVEL_BONUS(10),
    .LAVA_W(10), .LAVA_TOP(10), .LAVA_SPEED(3), .BOOST_STEP(1), .MAX_SPEED(8),
    .DEATH_TICKS(2), .CLEAR_TICKS(2), .SPAWN_X(20), .SPAWN_Y(344)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .pause_btn(pause_btn),
    .in_lava(in_lava), .at_goal(at_goal), .jump_landed(jump_landed),
    .game_tick(game_tick), .state(state), .freeze(freeze), .level(level),
    .lives(lives), .score(score), .lava_height(lava_height),
    .lava_rising(lava_rising), .spawn_pulse(spawn_pulse),
    .spawn_x(spawn_x), .spawn_y(spawn_y)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a game_tick strobe, then sample one negedge after
  // the update edge.
  task automatic tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!game_tick && n < 16);
    last_n = n;
    chk("tick_seen", 32'(game_tick), 1);
    @(negedge clk);
  endtask

  task automatic land_then_tick();
    jump_landed = 1'b1;
    @(negedge clk);
    jump_landed = 1'b0;
    tick();
  endtask

  task automatic do_clear(input int exp_level);
    at_goal = 1'b1;
    tick();
    at_goal = 1'b0;
    chk("clear_enter", 32'(state), 4);
    tick();
    tick();
    chk("clear_run", 32'(state), 1);
    chk("clear_level", 32'(level), 32'(exp_level));
    chk("clear_lava", 32'(lava_height), 0);
    chk("clear_spawn", 32'(spawn_pulse), 1);
  endtask

  task automatic die(input int exp_lives);
    in_lava = 1'b1;
    tick();
    in_lava = 1'b0;
    chk("die_state", 32'(state), 3);
    chk("die_lives", 32'(lives), 32'(exp_lives));
    tick();
  endtask

  initial begin
    int lava_exp [9] = '{3, 6, 9, 10, 7, 4, 1, 0, 3};
    int rise_exp [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};

    rst = 1'b1; start = 1'b0; pause_btn = 1'b0;
    in_lava = 1'b0; at_goal = 1'b0; jump_landed = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_tick", 32'(game_tick), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_score", 32'(score), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_lava", 32'(lava_height), 0);
    chk("rst_rising", 32'(lava_rising), 1);
    chk("rst_spawn", 32'(spawn_pulse), 0);
    chk("rst_freeze", 32'(freeze), 1);
    chk("spawn_x", 32'(spawn_x), 20);
    chk("spawn_y", 32'(spawn_y), 344);

    // Start game
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", 32'(state), 1);
    chk("start_freeze", 32'(freeze), 0);
    chk("start_spawn", 32'(spawn_pulse), 1);
    chk("start_lives", 32'(lives), 3);
    chk("start_score", 32'(score), 0);
    @(negedge clk);
    chk("spawn_one_clk", 32'(spawn_pulse), 0);

    // Lava oscillation
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 1) chk("tick_period", 32'(last_n + 1), 4);
      chk($sformatf("lava_h%0d", i), 32'(lava_height), 32'(lava_exp[i]));
      chk($sformatf("lava_r%0d", i), 32'(lava_rising), 32'(rise_exp[i]));
    end

    // Pause toggle
    pause_btn = 1'b1;
    tick();
    chk("pause_state", 32'(state), 2);
    chk("pause_freeze", 32'(freeze), 1);
    chk("pause_lava", 32'(lava_height), 3);
    pause_btn = 1'b0;
    tick();
    chk("pause_hold", 32'(lava_height), 3);
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
    chk("resume_state", 32'(state), 1);
    chk("resume_lava", 32'(lava_height), 3);
    tick();
    chk("resume_step", 32'(lava_height), 6);

    // Landing: score+1, speed 3->4
    land_then_tick();
    chk("land_score", 32'(score), 1);
    chk("land_lava", 32'(lava_height), 9);
    tick();
    chk("boost_top", 32'(lava_height), 10);
    tick();
    chk("boost_fall", 32'(lava_height), 6);

    // Ten landings saturate speed at 8
    for (int i = 0; i < 10; i++) land_then_tick();
    chk("ten_land_score", 32'(score), 11);
    tick();
    chk("max_speed_lava", 32'(lava_height), 8);

    // Score saturation at 15
    for (int i = 0; i < 4; i++) land_then_tick();
    chk("score_15", 32'(score), 15);
    land_then_tick();
    chk("score_sat", 32'(score), 15);

    // Level clear with saturating bonus
    at_goal = 1'b1;
    tick();
    at_goal = 1'b0;
    chk("goal_state", 32'(state), 4);
    chk("goal_score", 32'(score), 15);
    chk("goal_level", 32'(level), 0);
    tick();
    chk("clear_wait", 32'(state), 4);
    tick();
    chk("clear_level1", 32'(level), 1);
    chk("clear_state", 32'(state), 1);
    chk("clear_lava0", 32'(lava_height), 0);
    chk("clear_spawn1", 32'(spawn_pulse), 1);
    tick();
    chk("speed_reset", 32'(lava_height), 3);

    // in_lava beats at_goal
    in_lava = 1'b1; at_goal = 1'b1;
    tick();
    in_lava = 1'b0; at_goal = 1'b0;
    chk("prio_state", 32'(state), 3);
    chk("prio_lives", 32'(lives), 2);
    tick();
    chk("dying_wait", 32'(state), 3);
    tick();
    chk("respawn_state", 32'(state), 1);
    chk("respawn_pulse", 32'(spawn_pulse), 1);
    chk("respawn_lava", 32'(lava_height), 0);
    chk("respawn_level", 32'(level), 1);

    // Remaining levels to WIN
    do_clear(2);
    do_clear(3);
    at_goal = 1'b1;
    tick();
    at_goal = 1'b0;
    chk("win_state", 32'(state), 6);
    chk("win_level", 32'(level), 3);
    start = 1'b1;
    tick();
    chk("win_idle", 32'(state), 0);
    chk("win_hold_lives", 32'(lives), 2);
    chk("win_hold_score", 32'(score), 15);
    tick();
    start = 1'b0;
    chk("restart_state", 32'(state), 1);
    chk("restart_level", 32'(level), 0);
    chk("restart_lives", 32'(lives), 3);
    chk("restart_score", 32'(score), 0);
    chk("restart_spawn", 32'(spawn_pulse), 1);

    // Lose all lives
    die(2);
    tick();
    chk("life2_run", 32'(state), 1);
    die(1);
    tick();
    chk("life1_run", 32'(state), 1);
    die(0);
    tick();
    chk("over_state", 32'(state), 5);
    chk("over_lives", 32'(lives), 0);
    chk("over_freeze", 32'(freeze), 1);
    start = 1'b1;
    tick();
    chk("over_idle", 32'(state), 0);

    // Reset during DYING
    tick();
    start = 1'b0;
    chk("rerun_state", 32'(state), 1);
    in_lava = 1'b1;
    tick();
    in_lava = 1'b0;
    chk("dying_pre_rst", 32'(state), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_dying_state", 32'(state), 0);
    chk("rst_dying_lives", 32'(lives), 3);
    chk("rst_dying_tick", 32'(game_tick), 0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
